// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared deck constants, FSM state encoding and card range helper
package rng_pkg;

  localparam int DECK_SIZE = 52;
  localparam int CARD_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CLEAR = 2'd2,
    SCAN  = 2'd3
  } state_t;

  function automatic logic card_in_range(input int card, input int deck);
    return (card >= 1) && (card <= deck);
  endfunction

endpackage

// File: rtl/rng_rr_arbiter.sv
// rtl/rng_rr_arbiter.sv - round-robin pick of the first request at or after the pointer
module rng_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any
);

  always_comb begin
    grant = ptr;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[(int'(ptr) + i) % N]) begin
        any   = 1'b1;
        grant = PW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/rng_deal_controller.sv
// rtl/rng_deal_controller.sv - deal sequencer sharing the card counter among players
// RNG_DEAL_FALLBACK_EN adds a bounded retry count and a lowest-free-card SCAN state.
module rng_deal_controller #(
  parameter int N_PLAYERS = 4,
  parameter int DECK_SIZE = rng_pkg::DECK_SIZE,
  parameter int CARD_W    = rng_pkg::CARD_W,
  parameter int MAX_RETRY = 15,
  localparam int PW = $clog2(N_PLAYERS),
  localparam int IW = $clog2(DECK_SIZE)
) (
  input  logic                 clk_ctl_i,
  input  logic                 rst_ctl_i,
  input  logic [N_PLAYERS-1:0] req_i,
  input  logic                 shuffle_i,
  input  logic [CARD_W-1:0]    card_i,
  output logic                 run_counter_o,
  output logic [CARD_W-1:0]    card_o,
  output logic [PW-1:0]        player_o,
  output logic                 card_valid_o,
  output logic [5:0]           cards_left_o,
  output logic                 deck_empty_o,
  output logic                 busy_o
);
  import rng_pkg::*;

  if (N_PLAYERS < 2 || N_PLAYERS > 8 || DECK_SIZE > 63 || MAX_RETRY < 1) begin : g_param_check
    $error("rng_deal_controller: unsupported parameter combination");
  end

  state_t                state_q, state_d;
  logic [DECK_SIZE-1:0]  mask_q;
  logic [5:0]            left_q;
  logic [PW-1:0]         ptr_q, grant_q, arb_grant, player_q;
  logic                  arb_any, pend_q, run_q, valid_q;
  logic [CARD_W-1:0]     card_q, accept_card;
  logic                  take_grant, accept, do_clear, deck_empty, draw_ok;
  logic [IW-1:0]         draw_idx, accept_idx;

`ifdef RNG_DEAL_FALLBACK_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q;
  logic [IW-1:0] scan_q;
`endif

  rng_rr_arbiter #(.N(N_PLAYERS), .PW(PW)) u_arb (
    .req   (req_i),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .any   (arb_any)
  );

  assign deck_empty = (left_q == 6'd0);
  assign draw_idx   = IW'(card_i - CARD_W'(1));
  assign accept_idx = IW'(accept_card - CARD_W'(1));
  // Range is checked first so an out-of-deck value never selects a mask bit.
  assign draw_ok    = card_in_range(int'(card_i), DECK_SIZE) && !mask_q[draw_idx];

  always_ff @(posedge clk_ctl_i or posedge rst_ctl_i) begin
    if (rst_ctl_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    take_grant  = 1'b0;
    accept      = 1'b0;
    accept_card = '0;
    do_clear    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q || shuffle_i) begin
          state_d = CLEAR;
        end else if (arb_any && !deck_empty) begin
          take_grant = 1'b1;
          state_d    = DRAW;
        end
      end
      DRAW: begin
        if (draw_ok) begin
          accept      = 1'b1;
          accept_card = card_i;
          state_d     = IDLE;
        end
`ifdef RNG_DEAL_FALLBACK_EN
        else if (int'(retry_q) == MAX_RETRY - 1) begin
          state_d = SCAN;
        end
`endif
      end
      CLEAR: begin
        do_clear = 1'b1;
        state_d  = IDLE;
      end
      SCAN: begin
`ifdef RNG_DEAL_FALLBACK_EN
        if (!mask_q[scan_q]) begin
          accept      = 1'b1;
          accept_card = CARD_W'(scan_q) + CARD_W'(1);
          state_d     = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ctl_i or posedge rst_ctl_i) begin
    if (rst_ctl_i) begin
      mask_q   <= '0;
      left_q   <= 6'(DECK_SIZE);
      ptr_q    <= '0;
      grant_q  <= '0;
      player_q <= '0;
      card_q   <= '0;
      pend_q   <= 1'b0;
      run_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      valid_q <= accept;
      if (take_grant) grant_q <= arb_grant;
      if (do_clear) pend_q <= 1'b0;
      else if (shuffle_i && state_q != IDLE) pend_q <= 1'b1;
      if (accept) begin
        mask_q[accept_idx] <= 1'b1;
        left_q   <= left_q - 6'd1;
        card_q   <= accept_card;
        player_q <= grant_q;
        ptr_q    <= (int'(grant_q) == N_PLAYERS - 1) ? '0 : grant_q + PW'(1);
      end
      if (do_clear) begin
        mask_q <= '0;
        left_q <= 6'(DECK_SIZE);
      end
    end
  end

`ifdef RNG_DEAL_FALLBACK_EN
  always_ff @(posedge clk_ctl_i or posedge rst_ctl_i) begin
    if (rst_ctl_i) begin
      retry_q <= '0;
      scan_q  <= '0;
    end else begin
      if (take_grant) retry_q <= '0;
      else if (state_q == DRAW && !draw_ok) retry_q <= retry_q + RW'(1);
      if (state_q == DRAW) scan_q <= '0;
      else if (state_q == SCAN) scan_q <= scan_q + IW'(1);
    end
  end
`endif

  assign run_counter_o = run_q;
  assign card_o        = card_q;
  assign player_o      = player_q;
  assign card_valid_o  = valid_q;
  assign cards_left_o  = left_q;
  assign deck_empty_o  = deck_empty;
  assign busy_o        = (state_q != IDLE);

endmodule
